// File: rtl/pipe_stage_reg.sv
// Pipeline register between two core stages with valid/ready handshake, stall, flush and bubble insertion.
// Define YSYX_22040931_SKID_BUF_EN to add a skid entry so in_ready is driven from a register.
module pipe_stage_reg #(
  parameter int unsigned             PC_W     = 64,
  parameter int unsigned             INST_W   = 32,
  parameter logic [PC_W-1:0]         RESET_PC = '0,
  parameter logic [INST_W-1:0]       NOP_INST = 32'h00000013
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [INST_W-1:0] in_instr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [INST_W-1:0] out_instr
);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; a valid payload holds stable until its transfer completes.

  logic main_valid;
  logic in_fire;
  logic out_fire;

  assign out_valid = main_valid;
  assign out_fire  = main_valid & out_ready;
  assign in_fire   = in_valid & in_ready;

`ifdef YSYX_22040931_SKID_BUF_EN

  logic              skid_valid;
  logic [PC_W-1:0]   skid_pc;
  logic [INST_W-1:0] skid_instr;

  // Ready depends only on skid occupancy, breaking the path from out_ready.
  assign in_ready = ~skid_valid;

  always_ff @(posedge clock) begin
    if (reset) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      out_pc     <= RESET_PC;
      out_instr  <= NOP_INST;
      skid_pc    <= RESET_PC;
      skid_instr <= NOP_INST;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      out_instr  <= NOP_INST;
    end else if (skid_valid) begin
      // Skid full means in_ready is low, so only the skid-to-main move can occur.
      if (out_fire) begin
        out_pc     <= skid_pc;
        out_instr  <= skid_instr;
        skid_valid <= 1'b0;
      end
    end else if (!main_valid || out_ready) begin
      if (in_fire) begin
        main_valid <= 1'b1;
        out_pc     <= in_pc;
        out_instr  <= in_instr;
      end else begin
        main_valid <= 1'b0;
        out_instr  <= NOP_INST;
      end
    end else if (in_fire) begin
      skid_valid <= 1'b1;
      skid_pc    <= in_pc;
      skid_instr <= in_instr;
    end
  end

`else

  assign in_ready = ~main_valid | out_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      main_valid <= 1'b0;
      out_pc     <= RESET_PC;
      out_instr  <= NOP_INST;
    end else if (flush) begin
      main_valid <= 1'b0;
      out_instr  <= NOP_INST;
    end else if (in_fire) begin
      // Covers both the empty stage and drain-with-refill in one cycle.
      main_valid <= 1'b1;
      out_pc     <= in_pc;
      out_instr  <= in_instr;
    end else if (out_fire) begin
      main_valid <= 1'b0;
      out_instr  <= NOP_INST;
    end
  end

`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed plus random bench for pipe_stage_reg with a scoreboard of expected PCs in acceptance order.
module tb_pipe_stage_reg;

  localparam int unsigned       PC_W     = 64;
  localparam int unsigned       INST_W   = 32;
  localparam logic [PC_W-1:0]   RESET_PC = '0;
  localparam logic [INST_W-1:0] NOP_INST = 32'h00000013;
`ifdef YSYX_22040931_SKID_BUF_EN
  localparam int CAPACITY = 2;
`else
  localparam int CAPACITY = 1;
`endif

  logic              clock;
  logic              reset;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [PC_W-1:0]   in_pc;
  logic [INST_W-1:0] in_instr;
  logic              out_valid;
  logic              out_ready;
  logic [PC_W-1:0]   out_pc;
  logic [INST_W-1:0] out_instr;

  pipe_stage_reg #(
    .PC_W(PC_W), .INST_W(INST_W), .RESET_PC(RESET_PC), .NOP_INST(NOP_INST)
  ) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [PC_W-1:0] exp_q[$];
  logic [PC_W-1:0] last_pc;
  int n_checks;
  int n_fail;

  function automatic logic [INST_W-1:0] instr_of(input logic [PC_W-1:0] pc);
    return pc[31:0] ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string tag, input logic [PC_W-1:0] obs, input logic [PC_W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at the falling edge, check just after, then let the rising edge happen.
  task automatic cycle(input logic v, input logic [PC_W-1:0] pc, input logic ordy,
                       input logic fl, input logic rst, output logic acc);
    logic exp_ready;
    in_valid  = v;
    in_pc     = pc;
    in_instr  = instr_of(pc);
    out_ready = ordy;
    flush     = fl;
    reset     = rst;
    #1;
    if (CAPACITY == 2) exp_ready = (exp_q.size() < 2);
    else               exp_ready = (exp_q.size() == 0) || ordy;
    if (!rst) begin
      chk("in_ready",  {63'd0, in_ready},  {63'd0, exp_ready});
      chk("out_valid", {63'd0, out_valid}, {63'd0, exp_q.size() > 0});
      chk("out_pc",    out_pc, (exp_q.size() > 0) ? exp_q[0] : last_pc);
      chk("out_instr", {32'd0, out_instr},
          {32'd0, (exp_q.size() > 0) ? instr_of(exp_q[0]) : NOP_INST});
    end
    acc = v & exp_ready & ~rst;
    if (rst) begin
      exp_q.delete();
      last_pc = RESET_PC;
    end else if (fl) begin
      exp_q.delete();
    end else begin
      if (exp_q.size() > 0 && ordy) void'(exp_q.pop_front());
      if (acc) exp_q.push_back(pc);
    end
    if (exp_q.size() > 0) last_pc = exp_q[0];
    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    logic a;
    logic sent;
    logic [PC_W-1:0] rpc;
    n_checks = 0;
    n_fail   = 0;
    last_pc  = RESET_PC;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_pc = '0; in_instr = '0; out_ready = 1'b0;
    @(negedge clock);

    // Reset held two cycles while upstream offers a payload.
    cycle(1'b1, 64'h8000_0000, 1'b1, 1'b0, 1'b1, a);
    cycle(1'b1, 64'h8000_0000, 1'b1, 1'b0, 1'b1, a);
    cycle(1'b0, 64'h0, 1'b1, 1'b0, 1'b0, a);

    // Streaming at full throughput.
    for (int i = 0; i < 3; i++) cycle(1'b1, 64'h8000_0000 + 64'(4 * i), 1'b1, 1'b0, 1'b0, a);
    cycle(1'b0, 64'h0, 1'b1, 1'b0, 1'b0, a);
    cycle(1'b0, 64'h0, 1'b1, 1'b0, 1'b0, a);

    // Stall holding 0x80000004 while 0x80000008 is offered.
    cycle(1'b1, 64'h8000_0004, 1'b1, 1'b0, 1'b0, a);
    sent = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle(~sent, 64'h8000_0008, 1'b0, 1'b0, 1'b0, a);
      sent |= a;
    end
    for (int i = 0; i < 4 && !sent; i++) begin
      cycle(1'b1, 64'h8000_0008, 1'b1, 1'b0, 1'b0, a);
      sent |= a;
    end
    chk("stall_sent", {63'd0, sent}, 64'd1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 64'h0, 1'b1, 1'b0, 1'b0, a);

    // Flush wins over a concurrent accept.
    cycle(1'b1, 64'h8000_000C, 1'b1, 1'b0, 1'b0, a);
    cycle(1'b1, 64'h8000_0010, 1'b0, 1'b1, 1'b0, a);
    cycle(1'b0, 64'h0, 1'b1, 1'b0, 1'b0, a);
    cycle(1'b0, 64'h0, 1'b1, 1'b0, 1'b0, a);

    // Empty stage accepts under back-pressure and holds until released.
    cycle(1'b1, 64'h8000_0020, 1'b0, 1'b0, 1'b0, a);
    chk("empty_accept", {63'd0, a}, 64'd1);
    cycle(1'b0, 64'h0, 1'b0, 1'b0, 1'b0, a);
    cycle(1'b0, 64'h0, 1'b0, 1'b0, 1'b0, a);
    cycle(1'b0, 64'h0, 1'b1, 1'b0, 1'b0, a);
    cycle(1'b0, 64'h0, 1'b1, 1'b0, 1'b0, a);

    // Reset while stalled with the stage full.
    cycle(1'b1, 64'h8000_0030, 1'b0, 1'b0, 1'b0, a);
    cycle(1'b1, 64'h8000_0034, 1'b0, 1'b0, 1'b0, a);
    cycle(1'b0, 64'h0, 1'b0, 1'b0, 1'b1, a);
    cycle(1'b0, 64'h0, 1'b0, 1'b0, 1'b0, a);
    cycle(1'b0, 64'h0, 1'b1, 1'b0, 1'b0, a);

    // Random traffic with occasional flushes.
    rpc = 64'h9000_0000;
    for (int i = 0; i < 200; i++) begin
      cycle(1'($urandom_range(0, 1)), rpc, 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 15) == 0), 1'b0, a);
      if (a) rpc += 64'd4;
    end
    for (int i = 0; i < 4; i++) cycle(1'b0, 64'h0, 1'b1, 1'b0, 1'b0, a);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised pipeline register sitting between any two core stages: IF/ID, ID/EX, EX/MEM or MEM/WB.
- Successor to the fixed-width, always-advancing stage register.
- Adds a valid/ready handshake, stall (back-pressure), synchronous flush, and a configurable bubble instruction.
- An optional skid buffer removes the combinational ready path between stages.

Parameters:
- PC_W, 64, width of the PC field.
- INST_W, 32, width of the instruction field.
- RESET_PC, 0, value loaded into out_pc at reset.
- NOP_INST, 32'h00000013, bubble instruction (addi x0,x0,0) driven when the stage holds no valid entry.

Ports:
- clock  input  1  stage clock.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  kill all held entries (branch mispredict / trap).
- in_valid  input  1  upstream payload valid.
- in_ready  output  1  stage can accept this cycle.
- in_pc  input  PC_W  upstream PC.
- in_instr  input  INST_W  upstream instruction.
- out_valid  output  1  downstream payload valid.
- out_ready  input  1  downstream accepts this cycle.
- out_pc  output  PC_W  registered PC.
- out_instr  output  INST_W  registered instruction.

Behaviour:
- Clocking and reset:
  - Reset is synchronous, active-high; the stage is clocked on the rising edge of clock.
  - Reset values: out_valid=0, out_pc=RESET_PC, out_instr=NOP_INST, all internal valid bits=0.
  - Reset has priority over flush and over every handshake.
- Handshake:
  - Input transfer occurs when in_valid & in_ready.
  - Output transfer occurs when out_valid & out_ready.
  - Latency is 1 cycle: data accepted at edge N appears on out_* after edge N, provided the stage was empty or draining.
- Stall rule:
  - While out_valid=1 & out_ready=0, out_valid, out_pc and out_instr hold stable.
  - An entry is never dropped or duplicated.
- Empty stage:
  - When no entry is valid, out_instr=NOP_INST and out_pc holds its last value.
  - Draining the final entry without a refill loads NOP_INST into out_instr.
- Ordering: entries leave in acceptance order.
- Flush:
  - At the edge where flush=1, all valid bits clear and out_instr<=NOP_INST.
  - An input accepted in the same cycle is discarded; flush wins.
  - in_ready keeps its normal definition during flush.
- Simultaneous drain and refill in the same cycle: the new entry replaces the old one with no bubble, giving full throughput of one entry per cycle.
- Default (single-entry) mode:
  - in_ready = ~out_valid | out_ready (combinational).
  - The stage has 1 entry of storage.

Optional Feature:
- Macro: YSYX_22040931_SKID_BUF_EN.
- Defined:
  - Adds a second (skid) entry behind the main entry.
  - in_ready = ~skid_valid, driven straight from a register, with no combinational path from out_ready.
  - Main full, out_ready=0, input accepted: the entry goes to skid.
  - Output fires while skid is valid: main<=skid and skid clears.
  - Main empty, or main firing with skid empty: main<=in.
  - Throughput is 1/cycle with 2 entries of storage; flush and reset clear both entries.
- Undefined: single-entry mode as above; no skid storage is instantiated.

Test Plan:
- Reset: hold reset 2 cycles with in_valid=1, in_pc=0x80000000 -> out_valid=0, out_pc=0, out_instr=0x00000013; no entry captured.
- Streaming: out_ready=1, PCs 0x80000000/04/08 on consecutive cycles -> out_pc shows the same sequence one cycle later, out_valid=1 each cycle, no bubbles.
- Stall: out_ready=0 for 3 cycles holding 0x80000004.
  - Default mode: out_pc stays 0x80000004 and in_ready=0.
  - Skid mode: 0x80000008 is accepted, then in_ready=0.
  - On release (both modes): output order is 0x80000004 then 0x80000008.
- Flush with concurrent accept: the stage holds 0x8000000C; flush=1 with in_valid=1, in_pc=0x80000010 -> next cycle out_valid=0, out_instr=0x00000013; 0x80000010 never appears at the output.
- Empty accept under back-pressure: stage empty, out_ready=0, in_valid=1 with 0x80000020 -> in_ready=1; next cycle out_valid=1, out_pc=0x80000020, and it is held until out_ready=1.
- Reset mid-stall: 2 entries held (skid mode), reset=1 for one cycle -> both entries gone, out_valid=0, out_instr=0x00000013, in_ready=1.
